// File: rtl/dfc_arbiter.sv
// Round-robin front end that shares one 8-entry buffer/pairwise-sum unit between two
// requesters, tracking which requester owns the loaded data.
module dfc_arbiter #(
  parameter int LOAD_LEN = 8,
  parameter int READ_LEN = 4,
  parameter int TMO      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rq0_valid,
  input  logic [1:0] rq0_op,
  output logic       rq0_ready,
  output logic       rq0_dreq,
  input  logic [7:0] rq0_data,
  output logic       rs0_valid,
  output logic [8:0] rs0_data,
  output logic       rs0_last,
  output logic       rs0_err,
  input  logic       rq1_valid,
  input  logic [1:0] rq1_op,
  output logic       rq1_ready,
  output logic       rq1_dreq,
  input  logic [7:0] rq1_data,
  output logic       rs1_valid,
  output logic [8:0] rs1_data,
  output logic       rs1_last,
  output logic       rs1_err,
  output logic [1:0] dfc_cmd,
  output logic       dfc_cmd_valid,
  output logic [7:0] dfc_datain,
  input  logic [8:0] dfc_dataout,
  input  logic       dfc_output_valid,
  input  logic       dfc_busy
);

  localparam int CMAX = (LOAD_LEN > READ_LEN) ? LOAD_LEN : READ_LEN;
  localparam int CW   = $clog2(CMAX);
  localparam int TW   = $clog2(TMO);

  typedef enum logic [1:0] {ST_ARB, ST_LOAD, ST_DRAIN, ST_REJ} state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            rr_last_q, rr_last_d;
  logic            owner_q, owner_d;
  logic            owner_vld_q, owner_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [1:0]      ready, dreq, rs_v, rs_l, rs_e;
  logic [8:0]      rs_d [2];
  logic [1:0]      cmd;
  logic            cmd_v;
  logic [7:0]      datain;

  logic            sel, any_req, illegal;
  logic [1:0]      sel_op;

  // Both requesting: the one that did not win last time goes first.
  always_comb begin
    any_req = rq0_valid | rq1_valid;
    if (rq0_valid && rq1_valid) sel = ~rr_last_q;
    else                        sel = rq1_valid;
    sel_op  = sel ? rq1_op : rq0_op;
    illegal = (sel_op == 2'd3) ||
              ((sel_op != 2'd0) && (!owner_vld_q || (owner_q != sel)));
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    ready       = '0;
    dreq        = '0;
    rs_v        = '0;
    rs_l        = '0;
    rs_e        = '0;
    rs_d[0]     = '0;
    rs_d[1]     = '0;
    cmd         = '0;
    cmd_v       = 1'b0;
    datain      = '0;

    unique case (state_q)
      ST_ARB: begin
        if (any_req) begin
          // Rejections never touch the unit, so they are not held off by busy.
          if (illegal) begin
            ready[sel] = 1'b1;
            gnt_d      = sel;
            rr_last_d  = sel;
            state_d    = ST_REJ;
          end else if (!dfc_busy) begin
            ready[sel] = 1'b1;
            cmd_v      = 1'b1;
            cmd        = sel_op;
            gnt_d      = sel;
            rr_last_d  = sel;
            cnt_d      = '0;
            tmo_d      = '0;
            if (sel_op == 2'd0) begin
              owner_vld_d = 1'b0;
              state_d     = ST_LOAD;
            end else begin
              state_d     = ST_DRAIN;
            end
          end
        end
      end

      ST_LOAD: begin
        dreq[gnt_q] = 1'b1;
        datain      = gnt_q ? rq1_data : rq0_data;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CW'(LOAD_LEN - 1)) begin
          owner_d     = gnt_q;
          owner_vld_d = 1'b1;
          state_d     = ST_ARB;
        end
      end

      ST_DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        if (dfc_output_valid && (cnt_q == CW'(READ_LEN - 1))) begin
          rs_v[gnt_q] = 1'b1;
          rs_d[gnt_q] = dfc_dataout;
          rs_l[gnt_q] = 1'b1;
          state_d     = ST_ARB;
        end else if (tmo_q == TW'(TMO - 1)) begin
          rs_v[gnt_q] = 1'b1;
          rs_e[gnt_q] = 1'b1;
          rs_l[gnt_q] = 1'b1;
          state_d     = ST_ARB;
        end else if (dfc_output_valid) begin
          rs_v[gnt_q] = 1'b1;
          rs_d[gnt_q] = dfc_dataout;
          cnt_d       = cnt_q + 1'b1;
        end
      end

      ST_REJ: begin
        rs_v[gnt_q] = 1'b1;
        rs_e[gnt_q] = 1'b1;
        rs_l[gnt_q] = 1'b1;
        state_d     = ST_ARB;
      end

      default: state_d = ST_ARB;
    endcase

    // Outputs are forced quiet while reset is held, whatever state is registered.
    if (reset) begin
      ready   = '0;
      dreq    = '0;
      rs_v    = '0;
      rs_l    = '0;
      rs_e    = '0;
      rs_d[0] = '0;
      rs_d[1] = '0;
      cmd     = '0;
      cmd_v   = 1'b0;
      datain  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rq0_ready     = ready[0];
  assign rq1_ready     = ready[1];
  assign rq0_dreq      = dreq[0];
  assign rq1_dreq      = dreq[1];
  assign rs0_valid     = rs_v[0];
  assign rs1_valid     = rs_v[1];
  assign rs0_last      = rs_l[0];
  assign rs1_last      = rs_l[1];
  assign rs0_err       = rs_e[0];
  assign rs1_err       = rs_e[1];
  assign rs0_data      = rs_d[0];
  assign rs1_data      = rs_d[1];
  assign dfc_cmd       = cmd;
  assign dfc_cmd_valid = cmd_v;
  assign dfc_datain    = datain;

endmodule

// File: tb/tb_dfc_arbiter.sv
// Bench for dfc_arbiter: a behavioural buffer/sum unit plus an ownership/result model
// driven by directed and random requests.
module tb_dfc_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       rq_valid [2];
  logic [1:0] rq_op    [2];
  logic [7:0] rq_data  [2];
  logic       rq_ready [2];
  logic       rq_dreq  [2];
  logic       rs_valid [2];
  logic [8:0] rs_data  [2];
  logic       rs_last  [2];
  logic       rs_err   [2];
  logic [1:0] dfc_cmd;
  logic       dfc_cmd_valid;
  logic [7:0] dfc_datain;
  logic [8:0] dfc_dataout;
  logic       dfc_output_valid;
  logic       dfc_busy;

  always #5 clk = ~clk;

  dfc_arbiter dut (
    .clk(clk), .reset(reset),
    .rq0_valid(rq_valid[0]), .rq0_op(rq_op[0]), .rq0_ready(rq_ready[0]),
    .rq0_dreq(rq_dreq[0]), .rq0_data(rq_data[0]),
    .rs0_valid(rs_valid[0]), .rs0_data(rs_data[0]), .rs0_last(rs_last[0]), .rs0_err(rs_err[0]),
    .rq1_valid(rq_valid[1]), .rq1_op(rq_op[1]), .rq1_ready(rq_ready[1]),
    .rq1_dreq(rq_dreq[1]), .rq1_data(rq_data[1]),
    .rs1_valid(rs_valid[1]), .rs1_data(rs_data[1]), .rs1_last(rs_last[1]), .rs1_err(rs_err[1]),
    .dfc_cmd(dfc_cmd), .dfc_cmd_valid(dfc_cmd_valid), .dfc_datain(dfc_datain),
    .dfc_dataout(dfc_dataout), .dfc_output_valid(dfc_output_valid), .dfc_busy(dfc_busy)
  );

  // Shared unit: captures 8 bytes after a load cmd; a read streams the 4 sums
  // mem[i]+mem[i+4] (ascending for FIFO, descending for LIFO) on the next 4 cycles.
  logic [7:0] u_mem [8];
  logic [1:0] u_mode = 2'd0;
  logic [2:0] u_cnt = 3'd0;
  logic       u_lifo = 1'b0;
  logic [1:0] u_idx;
  logic       force_busy, mute;

  always @(posedge clk) begin
    if (reset) begin
      u_mode <= 2'd0;
      u_cnt  <= 3'd0;
    end else begin
      case (u_mode)
        2'd0: if (dfc_cmd_valid) begin
          u_cnt <= 3'd0;
          if (dfc_cmd == 2'd0) u_mode <= 2'd1;
          else if (!mute) begin
            u_mode <= 2'd2;
            u_lifo <= (dfc_cmd == 2'd2);
          end
        end
        2'd1: begin
          u_mem[u_cnt] <= dfc_datain;
          u_cnt        <= u_cnt + 3'd1;
          if (u_cnt == 3'd7) u_mode <= 2'd0;
        end
        default: begin
          u_cnt <= u_cnt + 3'd1;
          if (u_cnt == 3'd3) u_mode <= 2'd0;
        end
      endcase
    end
  end

  assign u_idx            = u_lifo ? (2'd3 - u_cnt[1:0]) : u_cnt[1:0];
  assign dfc_output_valid = (u_mode == 2'd2);
  assign dfc_dataout      = (u_mode == 2'd2) ?
                            ({1'b0, u_mem[{1'b0, u_idx}]} + {1'b0, u_mem[{1'b1, u_idx}]}) : 9'd0;
  assign dfc_busy         = force_busy | (u_mode != 2'd0);

  // Reference model state
  bit         m_owner_vld;
  int         m_owner;
  logic [7:0] m_buf [8];
  int         total = 0;
  int         passed = 0;
  int         failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int n, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rq_ready[n] === 1'b1) begin
        ok = 1;
        break;
      end
      cycles++;
      @(posedge clk); #1;
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic err_beat(input int n, input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, rs_valid[n], 1);
    chk({tag, "_err"},   rs_err[n],   1);
    chk({tag, "_last"},  rs_last[n],  1);
    chk({tag, "_data"},  rs_data[n],  0);
    @(posedge clk); #1;
  endtask

  // Called at the accept negedge; ends at the start of the cycle after the last byte.
  task automatic load_body(input int n, input logic [7:0] b [8]);
    @(posedge clk); #1;
    rq_valid[n] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rq_data[n] = b[k];
      @(negedge clk);
      chk("load_dreq", rq_dreq[n], 1);
      chk("load_datain", dfc_datain, b[k]);
      chk("load_other_dreq", rq_dreq[1-n], 0);
      chk("load_no_rs", rs_valid[n], 0);
      @(posedge clk); #1;
    end
    m_owner     = n;
    m_owner_vld = 1;
    for (int k = 0; k < 8; k++) m_buf[k] = b[k];
  endtask

  task automatic run_op(input int n, input logic [1:0] op, input logic [7:0] b [8]);
    bit          legal;
    int          cyc;
    int          idx;
    logic [8:0]  exp;
    legal = (op == 2'd0) || (op != 2'd3 && m_owner_vld && m_owner == n);
    $display("txn req%0d op%0d legal=%0d owner_vld=%0d owner=%0d mute=%0d",
             n, op, legal, m_owner_vld, m_owner, mute);
    rq_op[n]    = op;
    rq_valid[n] = 1'b1;
    wait_ready(n, cyc);
    if (rq_ready[n] !== 1'b1) begin
      rq_valid[n] = 1'b0;
      return;
    end
    chk("accept_cmd_valid", dfc_cmd_valid, legal);
    if (legal) chk("accept_cmd", dfc_cmd, op);
    if (!legal) begin
      @(posedge clk); #1;
      rq_valid[n] = 1'b0;
      err_beat(n, "rej");
    end else if (op == 2'd0) begin
      m_owner_vld = 0;
      load_body(n, b);
    end else begin
      @(posedge clk); #1;
      rq_valid[n] = 1'b0;
      if (mute) begin
        for (int c = 1; c < 16; c++) begin
          @(negedge clk);
          chk("tmo_quiet", rs_valid[n], 0);
          @(posedge clk); #1;
        end
        err_beat(n, "tmo");
      end else begin
        for (int bt = 0; bt < 4; bt++) begin
          idx = (op == 2'd1) ? bt : 3 - bt;
          exp = {1'b0, m_buf[idx]} + {1'b0, m_buf[idx+4]};
          @(negedge clk);
          chk("rd_valid", rs_valid[n], 1);
          chk("rd_data",  rs_data[n],  exp);
          chk("rd_last",  rs_last[n],  (bt == 3));
          chk("rd_err",   rs_err[n],   0);
          @(posedge clk); #1;
        end
      end
    end
  endtask

  logic [7:0] lb_a [8];
  logic [7:0] lb_b [8];
  int         cyc;
  int         r;
  int         rn;
  logic [1:0] rop;

  initial begin
    reset = 1'b1;
    force_busy = 1'b0;
    mute = 1'b0;
    m_owner_vld = 0;
    m_owner = 0;
    for (int i = 0; i < 2; i++) begin
      rq_valid[i] = 1'b0;
      rq_op[i]    = 2'd0;
      rq_data[i]  = 8'd0;
    end
    for (int k = 0; k < 8; k++) m_buf[k] = 8'd0;

    // Reset: outputs stay quiet even with a request pending
    rq_valid[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_ready", rq_ready[0], 0);
    chk("rst_cmd_valid", dfc_cmd_valid, 0);
    chk("rst_rs_valid", rs_valid[0], 0);
    chk("rst_datain", dfc_datain, 0);
    rq_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // FIFO before any load is rejected
    run_op(0, 2'd1, lb_a);

    // Load 01..08 then FIFO -> 006,008,00A,00C
    lb_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_op(0, 2'd0, lb_a);
    run_op(0, 2'd1, lb_a);

    // Carry into bit 8 on LIFO
    lb_a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01};
    run_op(0, 2'd0, lb_a);
    run_op(0, 2'd2, lb_a);

    // Non-owner read rejected; owner data survives; illegal op rejected
    run_op(1, 2'd1, lb_a);
    run_op(0, 2'd1, lb_a);
    run_op(1, 2'd3, lb_a);

    // Busy stalls a legal request
    force_busy = 1'b1;
    rq_op[0] = 2'd2;
    rq_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("busy_no_ready", rq_ready[0], 0);
      chk("busy_no_cmd", dfc_cmd_valid, 0);
      @(posedge clk); #1;
    end
    force_busy = 1'b0;
    run_op(0, 2'd2, lb_a);

    // Illegal op is accepted immediately even while busy
    force_busy = 1'b1;
    rq_op[1] = 2'd3;
    rq_valid[1] = 1'b1;
    wait_ready(1, cyc);
    chk("rej_busy_latency", cyc, 0);
    chk("rej_busy_cmd_valid", dfc_cmd_valid, 0);
    @(posedge clk); #1;
    rq_valid[1] = 1'b0;
    force_busy = 1'b0;
    err_beat(1, "rej_busy");

    // Unit never answers: watchdog error beat
    mute = 1'b1;
    run_op(0, 2'd1, lb_a);
    mute = 1'b0;

    // Simultaneous loads after reset: rq0 first, rq1 at T+9
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_owner_vld = 0;
    for (int k = 0; k < 8; k++) begin
      lb_a[k] = 8'($urandom);
      lb_b[k] = 8'($urandom);
    end
    rq_op[0] = 2'd0;
    rq_op[1] = 2'd0;
    rq_valid[0] = 1'b1;
    rq_valid[1] = 1'b1;
    $display("txn both-load rr");
    @(negedge clk);
    chk("rr_first_ready0", rq_ready[0], 1);
    chk("rr_first_ready1", rq_ready[1], 0);
    load_body(0, lb_a);
    wait_ready(1, cyc);
    chk("rr_second_latency", cyc, 0);
    chk("rr_second_cmd_valid", dfc_cmd_valid, 1);
    load_body(1, lb_b);
    run_op(1, 2'd1, lb_b);
    run_op(0, 2'd1, lb_b);

    // Reset in the middle of a load
    $display("txn req0 load aborted by reset");
    rq_op[0] = 2'd0;
    rq_valid[0] = 1'b1;
    wait_ready(0, cyc);
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rq_data[0] = 8'(k + 8'h40);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_dreq", rq_dreq[0], 0);
    chk("midrst_datain", dfc_datain, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_owner_vld = 0;
    @(negedge clk);
    chk("postrst_dreq", rq_dreq[0], 0);
    chk("postrst_rs_valid", rs_valid[0], 0);
    @(posedge clk); #1;
    run_op(0, 2'd1, lb_a);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      rn = int'($urandom_range(1, 0));
      r  = int'($urandom_range(9, 0));
      rop = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      for (int k = 0; k < 8; k++) lb_a[k] = 8'($urandom);
      run_op(rn, rop, lb_a);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
